// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: load-use / branch-operand stalls, flush, mem-wait freeze.
// Ports: clock, reset (async low), ID/EX/MEM hazard inputs, mem_busy, perf_clr ->
//   hz_pcwrite, hz_ifidwrite, hz_idexbubble, hz_ifidflush, hz_freeze, hz_state,
//   hz_cnt_stall/freeze/flush (live only when HZ_PERF_EN is defined).
module hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_addra,
  input  logic [RA_W-1:0]  id_addrb,
  input  logic             id_usea,
  input  logic             id_useb,
  input  logic             id_isbranch,
  input  logic             id_taken,
  input  logic [RA_W-1:0]  ex_regdest,
  input  logic             ex_writereg,
  input  logic             ex_readmem,
  input  logic [RA_W-1:0]  mem_regdest,
  input  logic             mem_readmem,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             hz_pcwrite,
  output logic             hz_ifidwrite,
  output logic             hz_idexbubble,
  output logic             hz_ifidflush,
  output logic             hz_freeze,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] hz_cnt_stall,
  output logic [CNT_W-1:0] hz_cnt_freeze,
  output logic [CNT_W-1:0] hz_cnt_flush
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_STALL   = 2'b01,
    S_MEMWAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    M_RUN,
    M_STALL,
    M_FREEZE,
    M_FLUSH
  } mode_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  mode_e      mode;

  logic ma_ex, mb_ex, ma_mem, mb_mem;
  logic hit_ex, hit_mem, ex_alu;
  logic need1, need2;

  // Register 0 is hardwired, so it never creates a dependency.
  assign ma_ex  = id_usea & (id_addra != '0)
                & (id_addra == ex_regdest);
  assign mb_ex  = id_useb & (id_addrb != '0)
                & (id_addrb == ex_regdest);
  assign ma_mem = id_usea & (id_addra != '0)
                & (id_addra == mem_regdest);
  assign mb_mem = id_useb & (id_addrb != '0)
                & (id_addrb == mem_regdest);

  assign hit_ex  = ma_ex | mb_ex;
  assign hit_mem = ma_mem | mb_mem;
  assign ex_alu  = ex_writereg & ~ex_readmem;

  // A branch compares in ID, so a load in EX needs two bubbles
  // before its data can be forwarded into decode.
  assign need2 = ex_readmem & hit_ex & id_isbranch;

  assign need1 = (ex_readmem & hit_ex & ~id_isbranch)
               | (ex_alu & hit_ex & id_isbranch)
               | (mem_readmem & hit_mem & id_isbranch);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode    = M_RUN;
    unique case (state_q)
      S_RUN, S_MEMWAIT: begin
        cnt_d = 2'd0;
        if (mem_busy) begin
          mode    = M_FREEZE;
          state_d = S_MEMWAIT;
        end else if (need2) begin
          mode    = M_STALL;
          state_d = S_STALL;
          cnt_d   = 2'd1;
        end else if (need1) begin
          mode    = M_STALL;
          state_d = S_RUN;
        end else if (id_taken) begin
          mode    = M_FLUSH;
          state_d = S_RUN;
        end else begin
          mode    = M_RUN;
          state_d = S_RUN;
        end
      end
      S_STALL: begin
        // The branch is still waiting on its operand here,
        // so its taken flag is not trusted yet.
        if (mem_busy) begin
          mode = M_FREEZE;
        end else begin
          mode = M_STALL;
          if (cnt_q <= 2'd1) begin
            state_d = S_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: begin
        mode    = M_STALL;
        state_d = S_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces the enables open in the same cycle,
  // even while a hazard is still presented on the inputs.
  always_comb begin
    hz_pcwrite    = 1'b1;
    hz_ifidwrite  = 1'b1;
    hz_idexbubble = 1'b0;
    hz_ifidflush  = 1'b0;
    hz_freeze     = 1'b0;
    if (reset) begin
      unique case (mode)
        M_STALL: begin
          hz_pcwrite    = 1'b0;
          hz_ifidwrite  = 1'b0;
          hz_idexbubble = 1'b1;
        end
        M_FREEZE: begin
          hz_pcwrite   = 1'b0;
          hz_ifidwrite = 1'b0;
          hz_freeze    = 1'b1;
        end
        M_FLUSH: begin
          hz_ifidflush = 1'b1;
        end
        default: begin
          hz_pcwrite   = 1'b1;
        end
      endcase
    end
  end

  assign hz_state = state_q;

`ifdef HZ_PERF_EN
  logic [CNT_W-1:0] stall_q, freeze_q, flush_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      freeze_q <= '0;
      flush_q  <= '0;
    end else if (perf_clr) begin
      stall_q  <= '0;
      freeze_q <= '0;
      flush_q  <= '0;
    end else begin
      if (hz_idexbubble && !(&stall_q))
        stall_q <= stall_q + 1'b1;
      if (hz_freeze && !(&freeze_q))
        freeze_q <= freeze_q + 1'b1;
      if (hz_ifidflush && !(&flush_q))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hz_cnt_stall  = stall_q;
  assign hz_cnt_freeze = freeze_q;
  assign hz_cnt_flush  = flush_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign hz_cnt_stall    = '0;
  assign hz_cnt_freeze   = '0;
  assign hz_cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic
// against a cycle-count reference model; a negedge monitor checks the outputs.
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int KMAX = (1 << CW) - 1;

  localparam int K_RUN = 0;
  localparam int K_STL = 1;
  localparam int K_FRZ = 2;
  localparam int K_FLS = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [RW-1:0] id_addra = '0;
  logic [RW-1:0] id_addrb = '0;
  logic id_usea = 1'b0;
  logic id_useb = 1'b0;
  logic id_isbranch = 1'b0;
  logic id_taken = 1'b0;
  logic [RW-1:0] ex_regdest = '0;
  logic ex_writereg = 1'b0;
  logic ex_readmem = 1'b0;
  logic [RW-1:0] mem_regdest = '0;
  logic mem_readmem = 1'b0;
  logic mem_busy = 1'b0;
  logic perf_clr = 1'b0;
  logic hz_pcwrite, hz_ifidwrite, hz_idexbubble;
  logic hz_ifidflush, hz_freeze;
  logic [1:0] hz_state;
  logic [CW-1:0] hz_cnt_stall, hz_cnt_freeze;
  logic [CW-1:0] hz_cnt_flush;

  hazard_ctrl #(.RA_W(RW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_addra(id_addra), .id_addrb(id_addrb),
    .id_usea(id_usea), .id_useb(id_useb),
    .id_isbranch(id_isbranch), .id_taken(id_taken),
    .ex_regdest(ex_regdest),
    .ex_writereg(ex_writereg),
    .ex_readmem(ex_readmem),
    .mem_regdest(mem_regdest),
    .mem_readmem(mem_readmem),
    .mem_busy(mem_busy), .perf_clr(perf_clr),
    .hz_pcwrite(hz_pcwrite),
    .hz_ifidwrite(hz_ifidwrite),
    .hz_idexbubble(hz_idexbubble),
    .hz_ifidflush(hz_ifidflush),
    .hz_freeze(hz_freeze), .hz_state(hz_state),
    .hz_cnt_stall(hz_cnt_stall),
    .hz_cnt_freeze(hz_cnt_freeze),
    .hz_cnt_flush(hz_cnt_flush)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic rst;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic ua, ub, br, tk;
    logic [RW-1:0] exd;
    logic exw, exr;
    logic [RW-1:0] md;
    logic mr, busy, pclr;
  } stim_t;

  typedef struct packed {
    logic pcw, ifw, bub, fl, fz;
    logic [1:0] st;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic [3*CW-1:0] k;
    int cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // Reference state: how many forced stall cycles remain,
  // whether we sit in a memory wait, and event tallies.
  int stall_left = 0;
  bit memwait = 0;
  int cs = 0, cf = 0, cl = 0;

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic int need(stim_t s);
    int n;
    bit ha, hm;
    n = 0;
    ha = (s.ua && s.a != 0 && s.a == s.exd)
      || (s.ub && s.b != 0 && s.b == s.exd);
    hm = (s.ua && s.a != 0 && s.a == s.md)
      || (s.ub && s.b != 0 && s.b == s.md);
    if (s.exr && ha) n = s.br ? 2 : 1;
    if (s.exw && !s.exr && ha && s.br && n < 1) n = 1;
    if (s.mr && hm && s.br && n < 1) n = 1;
    return n;
  endfunction

  function automatic int sat(int v);
    return (v < KMAX) ? v + 1 : KMAX;
  endfunction

  task automatic step(input stim_t s);
    exp_t x;
    int kind, n;
    @(posedge clock);
    #1;
    reset = s.rst;
    id_addra = s.a;
    id_addrb = s.b;
    id_usea = s.ua;
    id_useb = s.ub;
    id_isbranch = s.br;
    id_taken = s.tk;
    ex_regdest = s.exd;
    ex_writereg = s.exw;
    ex_readmem = s.exr;
    mem_regdest = s.md;
    mem_readmem = s.mr;
    mem_busy = s.busy;
    perf_clr = s.pclr;
    cyc++;
    x = '0;
    x.cyc = cyc;
    if (!s.rst) begin
      stall_left = 0;
      memwait = 0;
      cs = 0;
      cf = 0;
      cl = 0;
      x.c.pcw = 1'b1;
      x.c.ifw = 1'b1;
      q.push_back(x);
      return;
    end
    x.c.st = (stall_left > 0) ? 2'd1
           : memwait ? 2'd2 : 2'd0;
    if (s.busy) begin
      kind = K_FRZ;
      if (stall_left == 0) memwait = 1;
    end else if (stall_left > 0) begin
      kind = K_STL;
      stall_left--;
    end else begin
      memwait = 0;
      n = need(s);
      if (n > 0) begin
        kind = K_STL;
        stall_left = n - 1;
      end else if (s.tk) begin
        kind = K_FLS;
      end else begin
        kind = K_RUN;
      end
    end
    x.c.pcw = (kind == K_RUN || kind == K_FLS);
    x.c.ifw = (kind == K_RUN || kind == K_FLS);
    x.c.bub = (kind == K_STL);
    x.c.fl  = (kind == K_FLS);
    x.c.fz  = (kind == K_FRZ);
`ifdef HZ_PERF_EN
    x.k = {CW'(cs), CW'(cf), CW'(cl)};
    if (s.pclr) begin
      cs = 0;
      cf = 0;
      cl = 0;
    end else begin
      if (kind == K_STL) cs = sat(cs);
      if (kind == K_FRZ) cf = sat(cf);
      if (kind == K_FLS) cl = sat(cl);
    end
`else
    x.k = '0;
`endif
    q.push_back(x);
  endtask

  always @(negedge clock) begin
    exp_t e;
    ctl_t a;
    logic [3*CW-1:0] k;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {hz_pcwrite, hz_ifidwrite,
           hz_idexbubble, hz_ifidflush,
           hz_freeze, hz_state};
      k = {hz_cnt_stall, hz_cnt_freeze,
           hz_cnt_flush};
      checks++;
      if (a !== e.c) begin
        fails++;
        $display("FAIL ctl cyc%0d got pcw%b ifw%b bub%b fl%b fz%b st%b want pcw%b ifw%b bub%b fl%b fz%b st%b",
          e.cyc, a.pcw, a.ifw, a.bub, a.fl, a.fz, a.st,
          e.c.pcw, e.c.ifw, e.c.bub, e.c.fl,
          e.c.fz, e.c.st);
      end
      checks++;
      if (k !== e.k) begin
        fails++;
        $display("FAIL cnt cyc%0d got %h want %h",
          e.cyc, k, e.k);
      end
    end
  end

  stim_t s, s2;

  initial begin
    s = idle_s();
    s.rst = 1'b0;
    step(s);
    step(s);
    step(idle_s());

    // load-use, non-branch: one bubble
    s = idle_s();
    s.exr = 1; s.exw = 1; s.exd = 8;
    s.ua = 1; s.a = 8;
    step(s);
    step(idle_s());

    // load feeding a taken beq: two bubbles, then flush
    s = idle_s();
    s.exr = 1; s.exw = 1; s.exd = 8;
    s.br = 1; s.ub = 1; s.b = 8; s.tk = 1;
    s2 = idle_s();
    s2.br = 1; s2.tk = 1;
    step(s);
    step(s);
    step(s2);
    step(idle_s());

    // r0 never stalls
    s2 = idle_s();
    s2.exr = 1; s2.exd = 0; s2.ua = 1; s2.a = 0;
    step(s2);

    // memory wait in the middle of a two-cycle stall
    step(s);
    s.busy = 1;
    repeat (3) step(s);
    s.busy = 0;
    step(s);
    step(idle_s());

    // memory wait from RUN, released onto a hazard
    s2 = idle_s();
    s2.busy = 1;
    step(s2);
    step(s2);
    s.busy = 0;
    step(s);
    step(s);
    step(idle_s());

    // reset while stalled, then a normal load-use
    step(s);
    s2 = s;
    s2.rst = 0;
    step(s2);
    step(idle_s());
    s = idle_s();
    s.exr = 1; s.exw = 1; s.exd = 8;
    s.ua = 1; s.a = 8;
    step(s);
    step(idle_s());

    // counter clear
    s2 = idle_s();
    s2.pclr = 1;
    step(s2);
    step(idle_s());

    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 49) != 0);
      s.a    = RW'($urandom_range(0, 3));
      s.b    = RW'($urandom_range(0, 3));
      s.ua   = 1'($urandom_range(0, 1));
      s.ub   = 1'($urandom_range(0, 1));
      s.br   = 1'($urandom_range(0, 1));
      s.tk   = 1'($urandom_range(0, 1));
      s.exd  = RW'($urandom_range(0, 3));
      s.exw  = 1'($urandom_range(0, 1));
      s.exr  = 1'($urandom_range(0, 1));
      s.md   = RW'($urandom_range(0, 3));
      s.mr   = 1'($urandom_range(0, 1));
      s.busy = ($urandom_range(0, 6) == 0);
      s.pclr = ($urandom_range(0, 39) == 0);
      step(s);
    end
    step(idle_s());

    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0",
        q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
